// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: default parameters,
// FSM state encoding (listed in frame field order) and the byte-acceptance helper.
package prog_loader_pkg;

  localparam int         PROG_CTR_WID_DEF = 10;
  localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;

  // Frame order on the wire: SYNC, LEN_LO, LEN_HI, {DATA_LO, DATA_HI} x N, [CKSUM]
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SYNC    = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_LEN_HI  = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_DATA_HI = 4'd5,
`ifdef PROG_LOADER_CKSUM_EN
    ST_CKSUM   = 4'd6,
`endif
    ST_DONE    = 4'd7,
    ST_ERROR   = 4'd8
  } state_t;

  // Where the frame goes once the last data word (or an empty length) has been seen
`ifdef PROG_LOADER_CKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CKSUM;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  function automatic logic accepts_bytes(input state_t s);
    logic ok;
    case (s)
      ST_SYNC, ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI: ok = 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
      ST_CKSUM: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/prog_loader_cksum.sv
// Running XOR accumulator over the length and data bytes of a load frame.
// Only instantiated when PROG_LOADER_CKSUM_EN is defined.
module prog_loader_cksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] value
);

  logic [7:0] acc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= 8'h00;
    end else if (clear) begin
      acc_reg <= 8'h00;
    end else if (en) begin
      acc_reg <= acc_reg ^ data;
    end
  end

  assign value = acc_reg;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses SYNC/LEN/DATA[/CKSUM] byte frames into 16-bit
// instruction memory writes and holds the core in reset until a clean load.
// Optional checksum byte enabled by defining PROG_LOADER_CKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         PROG_CTR_WID = PROG_CTR_WID_DEF,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    start,
  output logic                    imem_wr_en,
  output logic [PROG_CTR_WID-1:0] imem_wr_addr,
  output logic [15:0]             imem_wr_data,
  output logic                    proc_rst_n,
  output logic                    load_done,
  output logic                    load_err
);

  // Word index needs one extra bit so a completely full memory can be counted
  localparam int          IDX_WID  = PROG_CTR_WID + 1;
  localparam logic [16:0] CAPACITY = 17'(1) << PROG_CTR_WID;

  state_t                  state_reg, state_next;
  logic [15:0]             len_reg, len_next;
  logic [IDX_WID-1:0]      idx_reg, idx_next;
  logic [7:0]              lo_reg, lo_next;
  logic                    s_ready_reg;
  logic                    wr_en_reg, wr_en_next;
  logic [PROG_CTR_WID-1:0] wr_addr_reg, wr_addr_next;
  logic [15:0]             wr_data_reg, wr_data_next;
  logic                    done_reg, err_reg, proc_rst_n_reg;
  logic                    accept;
  logic                    restart;
  logic [15:0]             len_rx;

  assign accept = s_valid & s_ready_reg;
  assign len_rx = {s_data, len_reg[7:0]};

`ifdef PROG_LOADER_CKSUM_EN
  logic       cksum_en;
  logic [7:0] cksum_value;

  assign cksum_en = accept & (state_reg inside {ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI});

  prog_loader_cksum u_cksum (
    .clk   (clk),
    .reset (reset),
    .clear (restart),
    .en    (cksum_en),
    .data  (s_data),
    .value (cksum_value)
  );
`endif

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    idx_next     = idx_reg;
    lo_next      = lo_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    restart      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next   = ST_SYNC;
          restart      = 1'b1;
          idx_next     = '0;
          wr_addr_next = '0;
        end
      end
      ST_SYNC: begin
        if (accept && s_data == SYNC_BYTE) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_next[7:0] = s_data;
          state_next    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_next = len_rx;
          idx_next = '0;
          if ({1'b0, len_rx} > CAPACITY)  state_next = ST_ERROR;
          else if (len_rx == 16'd0)       state_next = ST_AFTER_DATA;
          else                            state_next = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          lo_next    = s_data;
          state_next = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          wr_en_next   = 1'b1;
          wr_addr_next = idx_reg[PROG_CTR_WID-1:0];
          wr_data_next = {s_data, lo_reg};
          idx_next     = idx_reg + IDX_WID'(1);
          if (17'(idx_reg) + 17'd1 == {1'b0, len_reg}) state_next = ST_AFTER_DATA;
          else                                          state_next = ST_DATA_LO;
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (accept) state_next = (s_data == cksum_value) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Flags and handshake are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      len_reg        <= 16'd0;
      idx_reg        <= '0;
      lo_reg         <= 8'h00;
      s_ready_reg    <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= 16'h0000;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      proc_rst_n_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      idx_reg        <= idx_next;
      lo_reg         <= lo_next;
      s_ready_reg    <= accepts_bytes(state_next);
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      done_reg       <= (state_next == ST_DONE);
      err_reg        <= (state_next == ST_ERROR);
      proc_rst_n_reg <= (state_next == ST_DONE);
    end
  end

  assign s_ready      = s_ready_reg;
  assign imem_wr_en   = wr_en_reg;
  assign imem_wr_addr = wr_addr_reg;
  assign imem_wr_data = wr_data_reg;
  assign load_done    = done_reg;
  assign load_err     = err_reg;
  assign proc_rst_n   = proc_rst_n_reg;

endmodule
